// File: rtl/hazard_scoreboard.sv
// Pipeline hazard controller: tracks in-flight writes in EX/MEM/WB and stalls,
// freezes or flushes the front end of the 5-stage core accordingly.
module hazard_scoreboard #(
  parameter int FORWARD_EN = 0,
  parameter int WB_BYPASS  = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [3:0]       id_src_1,
  input  logic [3:0]       id_src_2,
  input  logic             id_two_src,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic [3:0]       id_dest,
  input  logic             ex_branch_taken,
  input  logic             mem_stall,
  input  logic             cnt_clr,
  output logic             hazard,
  output logic             freeze,
  output logic             flush,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic       v;
    logic [3:0] dest;
    logic       ld;
  } slot_t;

  slot_t ex_q, mem_q, wb_q;
  logic  hit_ex, hit_mem, hit_wb;
  logic  raw;
  logic  flush_raw;
  logic  insert;

  function automatic logic slot_hit(input slot_t s, input logic [3:0] r1,
                                    input logic [3:0] r2, input logic two);
    return (s.v && (s.dest == r1)) || (two && s.v && (s.dest == r2));
  endfunction

  always_comb begin
    hit_ex  = slot_hit(ex_q,  id_src_1, id_src_2, id_two_src);
    hit_mem = slot_hit(mem_q, id_src_1, id_src_2, id_two_src);
    hit_wb  = slot_hit(wb_q,  id_src_1, id_src_2, id_two_src);
    if (FORWARD_EN != 0) begin
      raw = ex_q.ld & hit_ex;
    end else begin
      raw = hit_ex | hit_mem | ((WB_BYPASS == 0) & hit_wb);
    end
    flush_raw = ex_branch_taken & ~mem_stall;
    // All three control outputs are held low while reset is asserted.
    flush  = ~rst & flush_raw;
    hazard = ~rst & id_valid & raw & ~flush_raw;
    freeze = hazard | (~rst & mem_stall);
    insert = id_valid & ~hazard & ~flush & id_wb_en;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      stall_cnt <= '0;
    end else begin
      if (!mem_stall) begin
        wb_q  <= mem_q;
        mem_q <= ex_q;
        ex_q  <= insert ? slot_t'{v: 1'b1, dest: id_dest, ld: id_mem_r_en} : slot_t'('0);
      end
      if (cnt_clr) begin
        stall_cnt <= '0;
      end else if (hazard && !mem_stall && !(&stall_cnt)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule
